treasure_result_tx: RTL and testbench
=====================================

// Module: treasure_result_tx
// PURPOSE
//  Sends the per-frame shape/colour code from the image processor to the robot's Arduino.
//  Filters RESULT across frames and forwards only codes that are stable and changed.
//  Transfer uses a 4-phase REQ/ACK handshake on 3 parallel GPIO data lines.
//  Sits between the image processor and the GPIO header; ACK arrives asynchronously from the Arduino.
// PARAMETERS
//  STABLE_FRAMES   3          consecutive identical frame samples needed to accept a code (1..15)
//  SETUP_CYCLES    4          cycles data is driven before REQ rises (1..255)
//  TIMEOUT_CYCLES  2500000    max cycles waiting for each ACK edge (100 ms @ 25 MHz)
// PORTS
//  CLK            in   1  system clock (25 MHz pixel clock domain)
//  RST_N          in   1  asynchronous active-low reset
//  RESULT         in   3  code from image processor; updated at VGA VSYNC negedge
//  VGA_VSYNC_NEG  in   1  VGA vertical sync (active-low); frame marker
//  ACK            in   1  Arduino acknowledge; asynchronous to CLK
//  TREASURE_OUT   out  3  code presented to Arduino
//  REQ            out  1  handshake request
//  BUSY           out  1  1 whenever FSM is not IDLE
//  TIMEOUT_ERR    out  1  one-cycle pulse when a handshake phase times out
//  SENT_CNT       out  8  completed transfers; wraps 255 -> 0
// BEHAVIOUR
//  Reset (async on RST_N low, all regs): TREASURE_OUT=0, REQ=0, BUSY=0, TIMEOUT_ERR=0, SENT_CNT=0.
//   Internal: stable_val=0, last_sent=0, cand=0, stable_cnt=0, FSM=IDLE, ACK sync flops=0.
//   Reset mid-transfer aborts immediately. The Arduino sees REQ fall and returns to its idle state.
//  ACK sync: 2-flop synchronizer -> ack_s. Only ack_s is used; 2-3 cycles of latency are accepted.
//  Frame sampling: on VGA_VSYNC_NEG rising edge (prev=0, now=1), sample RESULT.
//   RESULT == cand: stable_cnt <= min(stable_cnt+1, STABLE_FRAMES).
//   RESULT != cand: cand <= RESULT, stable_cnt <= 1.
//   When the updated stable_cnt == STABLE_FRAMES, stable_val <= cand the same cycle.
//   Sampling runs continuously and is independent of FSM state.
//  pending = (stable_val != last_sent), combinational.
//   Code 000 is a valid code: a change back to 000 is transmitted.
//  FSM:
//   IDLE:    BUSY=0, REQ=0. If pending: TREASURE_OUT <= stable_val, cnt <= 0, go to SETUP.
//   SETUP:   REQ=0. Count SETUP_CYCLES cycles, then go to REQ_HI.
//   REQ_HI:  REQ=1.
//            ack_s=1: last_sent <= TREASURE_OUT, SENT_CNT++, cnt <= 0, go to REQ_LO.
//            cnt == TIMEOUT_CYCLES-1: go to ABORT.
//   REQ_LO:  REQ=0.
//            ack_s=0: go to IDLE.
//            cnt == TIMEOUT_CYCLES-1: go to ABORT. last_sent stays updated.
//   ABORT:   REQ=0, TIMEOUT_ERR=1 for exactly 1 cycle, then go to IDLE.
//            On an REQ_HI abort, last_sent is unchanged, so the code is retried.
//  TREASURE_OUT is held constant from SETUP entry until the next SETUP entry.
//  stable_val change during a transfer: the current transfer completes with the old value.
//   The new value is sent next if it still differs from last_sent.
//  ack_s already 1 when SETUP ends (stale ACK): REQ_HI completes on the first cycle.
//  REQ is registered and is never 1 outside REQ_HI.
//  Counter cnt is sized $clog2(TIMEOUT_CYCLES+1). stable_cnt is 4 bits.
// TESTING
//  1. Reset, hold RESULT=3'b011 for 3 VSYNC rises, ACK model with 5-cycle response.
//     -> TREASURE_OUT=011, REQ rises 4 cycles after SETUP entry, SENT_CNT=1, REQ=0 when done.
//  2. RESULT sequence 101,101,010,101,101,101 (one per frame).
//     -> exactly one transfer, code 101, after the 6th sample. 010 is never driven.
//  3. Tie ACK=0 after a stable 110.
//     -> REQ high for 2500000 cycles, then REQ=0, TIMEOUT_ERR one-cycle pulse.
//     -> retry starts (SETUP) the cycle after IDLE; SENT_CNT unchanged.
//  4. During REQ_HI, make RESULT stable at 001 (previous 100 in flight).
//     -> 100 completes, then 001 transfer follows; SENT_CNT +2.
//  5. Assert RST_N=0 while REQ=1.
//     -> REQ, TREASURE_OUT, BUSY go 0 asynchronously; after release, a stable 000 sends nothing.
//  6. Run 256 alternating transfers.
//     -> SENT_CNT wraps to 0; stable 010 then 000 results in two transfers, the second being 000.

Source files
------------

// File: rtl/treasure_result_tx.sv
// treasure_result_tx
//   Forwards the image processor's per-frame shape/colour code to the robot's
//   Arduino. A code is accepted only after it has been seen on STABLE_FRAMES
//   consecutive frames, and it is sent only when it differs from the last code
//   the Arduino acknowledged. Each transfer is a 4-phase REQ/ACK handshake on
//   three parallel data lines, with a per-phase timeout.
//
// Ports
//   CLK            in   system clock (25 MHz pixel domain)
//   RST_N          in   asynchronous active-low reset
//   RESULT[2:0]    in   code from the image processor, valid per frame
//   VGA_VSYNC_NEG  in   active-low VGA vsync; its rising edge marks a frame
//   ACK            in   Arduino acknowledge, asynchronous to CLK
//   TREASURE_OUT   out  code presented to the Arduino
//   REQ            out  handshake request
//   BUSY           out  high whenever a transfer is in progress
//   TIMEOUT_ERR    out  one-cycle pulse when a handshake phase times out
//   SENT_CNT[7:0]  out  completed transfers, wraps 255 -> 0
module treasure_result_tx #(
  parameter int STABLE_FRAMES  = 3,
  parameter int SETUP_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] RESULT,
  input  logic       VGA_VSYNC_NEG,
  input  logic       ACK,
  output logic [2:0] TREASURE_OUT,
  output logic       REQ,
  output logic       BUSY,
  output logic       TIMEOUT_ERR,
  output logic [7:0] SENT_CNT
);

  // One counter serves both the setup delay and the ACK timeouts.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [3:0]    SF         = 4'(STABLE_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_REQ_HI,
    S_REQ_LO,
    S_ABORT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          load_out;   // latch stable_val onto TREASURE_OUT
  logic          commit;     // Arduino accepted the code

  // ---------------------------------------------------------------------
  // ACK synchronizer
  // ---------------------------------------------------------------------
  logic ack_m, ack_s;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= ACK;
      ack_s <= ack_m;
    end
  end

  // ---------------------------------------------------------------------
  // Frame sampler / stability filter
  // ---------------------------------------------------------------------
  logic       vs_prev, frame_edge;
  logic [2:0] cand, stable_val, last_sent;
  logic [3:0] stable_cnt, stable_cnt_n;
  logic       pending;

  assign frame_edge = VGA_VSYNC_NEG & ~vs_prev;

  always_comb begin
    stable_cnt_n = 4'd1;
    if (RESULT == cand)
      stable_cnt_n = (stable_cnt >= SF) ? SF : stable_cnt + 4'd1;
  end

  // vs_prev resets high: vsync idles high, so a release of reset with vsync
  // already high must not be mistaken for a frame boundary.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vs_prev    <= 1'b1;
      cand       <= 3'd0;
      stable_cnt <= 4'd0;
      stable_val <= 3'd0;
    end else begin
      vs_prev <= VGA_VSYNC_NEG;
      if (frame_edge) begin
        cand       <= RESULT;
        stable_cnt <= stable_cnt_n;
        // RESULT is the updated candidate in both the match and reload cases.
        if (stable_cnt_n == SF)
          stable_val <= RESULT;
      end
    end
  end

  // 000 is a real code, so there is no "empty" value; only a difference counts.
  assign pending = (stable_val != last_sent);

  // ---------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    load_out = 1'b0;
    commit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending) begin
          state_n  = S_SETUP;
          cnt_n    = '0;
          load_out = 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_n = S_REQ_HI;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_REQ_HI: begin
        // A stale ACK already high completes this phase on its first cycle.
        if (ack_s) begin
          state_n = S_REQ_LO;
          cnt_n   = '0;
          commit  = 1'b1;
        end else if (cnt == TO_LAST) begin
          state_n = S_ABORT;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_REQ_LO: begin
        // The code was already accepted; a timeout here does not resend it.
        if (!ack_s)
          state_n = S_IDLE;
        else if (cnt == TO_LAST)
          state_n = S_ABORT;
        else
          cnt_n = cnt + CNT_ONE;
      end
      S_ABORT: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= S_IDLE;
      cnt          <= '0;
      TREASURE_OUT <= 3'd0;
      last_sent    <= 3'd0;
      SENT_CNT     <= 8'd0;
      REQ          <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      // Held from SETUP entry to the next SETUP entry, so the data lines stay
      // stable through the whole handshake even if stable_val moves.
      if (load_out)
        TREASURE_OUT <= stable_val;
      if (commit) begin
        last_sent <= TREASURE_OUT;
        SENT_CNT  <= SENT_CNT + 8'd1;
      end
      // Registered from the next state so REQ is high exactly in REQ_HI.
      REQ <= (state_n == S_REQ_HI);
    end
  end

  assign BUSY        = (state != S_IDLE);
  assign TIMEOUT_ERR = (state == S_ABORT);

endmodule

// File: tb/tb_treasure_result_tx.sv
`timescale 1ns/1ps
module tb_treasure_result_tx;

  // Short timeout keeps the timeout scenario inside the cycle budget.
  localparam int TO = 40;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [2:0] RESULT;
  logic       VSYNC;
  logic       ACK;
  logic [2:0] TREASURE_OUT;
  logic       REQ, BUSY, TIMEOUT_ERR;
  logic [7:0] SENT_CNT;

  treasure_result_tx #(
    .STABLE_FRAMES (3),
    .SETUP_CYCLES  (4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .RESULT       (RESULT),
    .VGA_VSYNC_NEG(VSYNC),
    .ACK          (ACK),
    .TREASURE_OUT (TREASURE_OUT),
    .REQ          (REQ),
    .BUSY         (BUSY),
    .TIMEOUT_ERR  (TIMEOUT_ERR),
    .SENT_CNT     (SENT_CNT)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int exp_sent = 0;

  int ack_mode = 0;   // 0: Arduino model follows REQ, 1: ACK tied low
  int ack_dly  = 5;   // model response time in cycles

  int n_to     = 0;   // cycles with TIMEOUT_ERR high
  int n_out010 = 0;   // cycles with TREASURE_OUT == 010
  int n_busy   = 0;   // cycles with BUSY high

  // Arduino model: ACK follows REQ after ack_dly cycles.
  initial begin
    int d;
    d   = 0;
    ACK = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (ack_mode != 0) begin
        ACK = 1'b0;
        d   = 0;
      end else if (REQ !== ACK) begin
        if (d >= ack_dly - 1) begin
          ACK = REQ;
          d   = 0;
        end else begin
          d++;
        end
      end else begin
        d = 0;
      end
    end
  end

  // Output monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge CLK);
      if (TIMEOUT_ERR === 1'b1) n_to++;
      if (TREASURE_OUT === 3'b010) n_out010++;
      if (BUSY === 1'b1) n_busy++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still active at 1 ms, want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  // One frame: vsync low for two cycles, rising edge sampled on the last tick.
  task automatic frame(input logic [2:0] c);
    RESULT = c;
    VSYNC  = 1'b0;
    tick(2);
    VSYNC  = 1'b1;
    tick(1);
  endtask

  task automatic frames3(input logic [2:0] c);
    frame(c); frame(c); frame(c);
  endtask

  task automatic wait_busy(input logic lvl, input int bound, output bit ok);
    int i;
    i = 0;
    while (BUSY !== lvl && i < bound) begin
      tick(1);
      i++;
    end
    ok = (BUSY === lvl);
  endtask

  task automatic wait_req_hi(input int bound, output bit ok);
    int i;
    i = 0;
    while (REQ !== 1'b1 && i < bound) begin
      tick(1);
      i++;
    end
    ok = (REQ === 1'b1);
  endtask

  task automatic test_reset;
    RST_N  = 1'b0;
    RESULT = 3'b000;
    VSYNC  = 1'b1;
    tick(3);
    checks++; if (TREASURE_OUT !== 3'd0) begin failures++; $display("FAIL reset_out: got %b want 000", TREASURE_OUT); end
    checks++; if (REQ !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", REQ); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    checks++; if (TIMEOUT_ERR !== 1'b0) begin failures++; $display("FAIL reset_to: got %b want 0", TIMEOUT_ERR); end
    checks++; if (SENT_CNT !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", SENT_CNT); end
    RST_N = 1'b1;
    tick(3);
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_idle: busy got %b want 0", BUSY); end
  endtask

  task automatic test_basic;
    bit ok;
    int n;
    frames3(3'b011);
    wait_busy(1'b1, 10, ok);
    checks++; if (!ok) begin failures++; $display("FAIL t1_start: busy got %b want 1", BUSY); end
    checks++; if (TREASURE_OUT !== 3'b011) begin failures++; $display("FAIL t1_data: got %b want 011", TREASURE_OUT); end
    n = 0;
    while (REQ !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    checks++; if (n != 4) begin failures++; $display("FAIL t1_setup_len: got %0d want 4", n); end
    wait_busy(1'b0, 200, ok);
    exp_sent++;
    checks++; if (!ok) begin failures++; $display("FAIL t1_done: busy got %b want 0", BUSY); end
    checks++; if (SENT_CNT !== 8'(exp_sent)) begin failures++; $display("FAIL t1_cnt: got %0d want %0d", SENT_CNT, exp_sent); end
    checks++; if (REQ !== 1'b0) begin failures++; $display("FAIL t1_req_low: got %b want 0", REQ); end
  endtask

  task automatic test_filter;
    logic [2:0] seq [6];
    int early, o0;
    bit ok;
    seq   = '{3'b101, 3'b101, 3'b010, 3'b101, 3'b101, 3'b101};
    early = 0;
    o0    = n_out010;
    for (int i = 0; i < 6; i++) begin
      frame(seq[i]);
      tick(2);
      if (i < 5 && BUSY !== 1'b0) early++;
    end
    checks++; if (early != 0) begin failures++; $display("FAIL t2_early: got %0d early transfers want 0", early); end
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL t2_start: busy got %b want 1", BUSY); end
    checks++; if (TREASURE_OUT !== 3'b101) begin failures++; $display("FAIL t2_data: got %b want 101", TREASURE_OUT); end
    wait_busy(1'b0, 200, ok);
    exp_sent++;
    checks++; if (SENT_CNT !== 8'(exp_sent)) begin failures++; $display("FAIL t2_cnt: got %0d want %0d", SENT_CNT, exp_sent); end
    checks++; if (n_out010 != o0) begin failures++; $display("FAIL t2_no010: got %0d cycles want 0", n_out010 - o0); end
  endtask

  task automatic test_timeout;
    bit ok;
    int n, t0;
    ack_mode = 1;
    t0 = n_to;
    frames3(3'b110);
    wait_busy(1'b1, 10, ok);
    wait_req_hi(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL t3_req: got %b want 1", REQ); end
    n = 0;
    while (REQ === 1'b1 && n < TO + 20) begin
      tick(1);
      n++;
    end
    checks++; if (n != TO) begin failures++; $display("FAIL t3_req_len: got %0d want %0d", n, TO); end
    checks++; if (TIMEOUT_ERR !== 1'b1) begin failures++; $display("FAIL t3_pulse: got %b want 1", TIMEOUT_ERR); end
    tick(1);
    checks++; if (TIMEOUT_ERR !== 1'b0) begin failures++; $display("FAIL t3_pulse_end: got %b want 0", TIMEOUT_ERR); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL t3_idle: busy got %b want 0", BUSY); end
    tick(1);
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL t3_retry: busy got %b want 1", BUSY); end
    checks++; if (TREASURE_OUT !== 3'b110) begin failures++; $display("FAIL t3_retry_data: got %b want 110", TREASURE_OUT); end
    checks++; if (SENT_CNT !== 8'(exp_sent)) begin failures++; $display("FAIL t3_cnt_hold: got %0d want %0d", SENT_CNT, exp_sent); end
    checks++; if (n_to - t0 != 1) begin failures++; $display("FAIL t3_pulse_width: got %0d want 1", n_to - t0); end
    ack_mode = 0;
    wait_busy(1'b0, 300, ok);
    exp_sent++;
    checks++; if (SENT_CNT !== 8'(exp_sent)) begin failures++; $display("FAIL t3_retry_cnt: got %0d want %0d", SENT_CNT, exp_sent); end
  endtask

  task automatic test_update_in_flight;
    bit ok;
    ack_dly = 25;
    frames3(3'b100);
    wait_busy(1'b1, 10, ok);
    wait_req_hi(20, ok);
    frames3(3'b001);
    checks++; if (REQ !== 1'b1) begin failures++; $display("FAIL t4_in_flight: req got %b want 1", REQ); end
    checks++; if (TREASURE_OUT !== 3'b100) begin failures++; $display("FAIL t4_hold: got %b want 100", TREASURE_OUT); end
    wait_busy(1'b0, 200, ok);
    exp_sent++;
    checks++; if (SENT_CNT !== 8'(exp_sent)) begin failures++; $display("FAIL t4_first_cnt: got %0d want %0d", SENT_CNT, exp_sent); end
    tick(1);
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL t4_second_start: busy got %b want 1", BUSY); end
    checks++; if (TREASURE_OUT !== 3'b001) begin failures++; $display("FAIL t4_second_data: got %b want 001", TREASURE_OUT); end
    wait_busy(1'b0, 300, ok);
    exp_sent++;
    checks++; if (SENT_CNT !== 8'(exp_sent)) begin failures++; $display("FAIL t4_second_cnt: got %0d want %0d", SENT_CNT, exp_sent); end
    ack_dly = 5;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int b0;
    frames3(3'b111);
    wait_busy(1'b1, 10, ok);
    wait_req_hi(20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL t5_req: got %b want 1", REQ); end
    #1 RST_N = 1'b0;
    #1;
    checks++; if (REQ !== 1'b0) begin failures++; $display("FAIL t5_req_async: got %b want 0", REQ); end
    checks++; if (TREASURE_OUT !== 3'd0) begin failures++; $display("FAIL t5_out_async: got %b want 000", TREASURE_OUT); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL t5_busy_async: got %b want 0", BUSY); end
    exp_sent = 0;
    tick(3);
    RST_N = 1'b1;
    b0 = n_busy;
    frames3(3'b000);
    tick(10);
    checks++; if (n_busy != b0) begin failures++; $display("FAIL t5_no_send: busy cycles got %0d want 0", n_busy - b0); end
    checks++; if (SENT_CNT !== 8'd0) begin failures++; $display("FAIL t5_cnt: got %0d want 0", SENT_CNT); end
  endtask

  task automatic test_wrap;
    bit ok;
    int bad;
    logic [2:0] c;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      c = i[0] ? 3'b110 : 3'b101;
      frames3(c);
      wait_busy(1'b1, 10, ok);
      if (!ok) bad++;
      wait_busy(1'b0, 200, ok);
      if (!ok) bad++;
      exp_sent++;
      if (i == 254) begin
        checks++; if (SENT_CNT !== 8'd255) begin failures++; $display("FAIL t6_cnt255: got %0d want 255", SENT_CNT); end
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL t6_handshakes: got %0d stalls want 0", bad); end
    checks++; if (SENT_CNT !== 8'd0) begin failures++; $display("FAIL t6_wrap: got %0d want 0", SENT_CNT); end
    frames3(3'b010);
    wait_busy(1'b1, 10, ok);
    checks++; if (TREASURE_OUT !== 3'b010) begin failures++; $display("FAIL t6_data010: got %b want 010", TREASURE_OUT); end
    wait_busy(1'b0, 200, ok);
    checks++; if (SENT_CNT !== 8'd1) begin failures++; $display("FAIL t6_cnt1: got %0d want 1", SENT_CNT); end
    frames3(3'b000);
    wait_busy(1'b1, 10, ok);
    checks++; if (!ok || TREASURE_OUT !== 3'b000) begin failures++; $display("FAIL t6_data000: busy %b out %b want busy 1 out 000", BUSY, TREASURE_OUT); end
    wait_busy(1'b0, 200, ok);
    checks++; if (SENT_CNT !== 8'd2) begin failures++; $display("FAIL t6_cnt2: got %0d want 2", SENT_CNT); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_timeout();
    test_update_in_flight();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
